// File: rtl/nn_bit_tx.sv
// rtl/nn_bit_tx.sv - parallel-to-serial word transmitter with one-word prefetch
//
// Serializes agg_width-bit words onto nn_in, with nn_1 qualifying each data bit.
// A holding register lets the next word be accepted while the current one shifts.
// Optional idle gap of GAP_CYCLES after each word.
//
// Ports:
//   clk        - clock, rising edge
//   rst        - asynchronous active-high reset
//   in_valid   - parallel word offered
//   in_data    - parallel word, sampled on accept
//   in_ready   - word can be accepted this cycle
//   nn_in      - serial data bit (registered)
//   nn_1       - high while nn_in carries a data bit (registered)
//   word_done  - pulse on the last bit of each word (registered)
//   busy       - shifting, in gap, or holding register full
//   words_sent - completed word count, wraps at 2^16

module nn_bit_tx #(
    parameter int agg_width  = 12,
    parameter int GAP_CYCLES = 0,
    parameter int MSB_FIRST  = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  logic [agg_width-1:0] in_data,
    output logic                 in_ready,
    output logic                 nn_in,
    output logic                 nn_1,
    output logic                 word_done,
    output logic                 busy,
    output logic [15:0]          words_sent
);

    typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

    localparam int CW = (agg_width > 1) ? $clog2(agg_width) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(agg_width - 1);
    localparam logic [3:0]    GAP_LAST = 4'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    state_t                 state_q, state_d;
    logic [agg_width-1:0]   shift_q, shift_d;
    logic [agg_width-1:0]   hold_q, hold_d;
    logic                   hold_full_q, hold_full_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [3:0]             gap_q, gap_d;
    logic                   nn_in_q, nn_in_d;
    logic                   nn_1_q, nn_1_d;
    logic                   word_done_q, word_done_d;
    logic [15:0]            words_sent_q;
    logic                   accept;

    function automatic logic [agg_width-1:0] advance(input logic [agg_width-1:0] v);
        return (MSB_FIRST != 0) ? (v << 1) : (v >> 1);
    endfunction

    function automatic logic out_bit(input logic [agg_width-1:0] v);
        return (MSB_FIRST != 0) ? v[agg_width-1] : v[0];
    endfunction

    assign in_ready   = !rst && !hold_full_q;
    assign accept     = in_valid && in_ready;
    assign busy       = (state_q != IDLE) || hold_full_q;
    assign nn_in      = nn_in_q;
    assign nn_1       = nn_1_q;
    assign word_done  = word_done_q;
    assign words_sent = words_sent_q;

    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        cnt_d       = cnt_q;
        gap_d       = gap_q;

        case (state_q)
            IDLE: begin
                // Empty pipeline: a new word bypasses the holding register.
                if (accept) begin
                    shift_d = in_data;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (cnt_q != LAST_BIT) begin
                    shift_d = advance(shift_q);
                    cnt_d   = cnt_q + 1'b1;
                    if (accept) begin
                        hold_d      = in_data;
                        hold_full_d = 1'b1;
                    end
                end else if (GAP_CYCLES > 0) begin
                    state_d = GAP;
                    gap_d   = '0;
                    if (accept) begin
                        hold_d      = in_data;
                        hold_full_d = 1'b1;
                    end
                end else if (hold_full_q) begin
                    shift_d     = hold_q;
                    hold_full_d = 1'b0;
                    cnt_d       = '0;
                end else if (accept) begin
                    // Word arriving on the last bit follows with no bubble.
                    shift_d = in_data;
                    cnt_d   = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            GAP: begin
                if (gap_q != GAP_LAST) begin
                    gap_d = gap_q + 1'b1;
                    if (accept) begin
                        hold_d      = in_data;
                        hold_full_d = 1'b1;
                    end
                end else if (hold_full_q) begin
                    shift_d     = hold_q;
                    hold_full_d = 1'b0;
                    cnt_d       = '0;
                    state_d     = SHIFT;
                end else if (accept) begin
                    shift_d = in_data;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Outputs are registered copies of what the next state will present.
        nn_1_d      = (state_d == SHIFT);
        nn_in_d     = nn_1_d && out_bit(shift_d);
        word_done_d = nn_1_d && (cnt_d == LAST_BIT);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            shift_q      <= '0;
            hold_q       <= '0;
            hold_full_q  <= 1'b0;
            cnt_q        <= '0;
            gap_q        <= '0;
            nn_in_q      <= 1'b0;
            nn_1_q       <= 1'b0;
            word_done_q  <= 1'b0;
            words_sent_q <= '0;
        end else begin
            state_q      <= state_d;
            shift_q      <= shift_d;
            hold_q       <= hold_d;
            hold_full_q  <= hold_full_d;
            cnt_q        <= cnt_d;
            gap_q        <= gap_d;
            nn_in_q      <= nn_in_d;
            nn_1_q       <= nn_1_d;
            word_done_q  <= word_done_d;
            words_sent_q <= words_sent_q + 16'(word_done_q);
        end
    end

endmodule

// File: tb/tb_nn_bit_tx.sv
// tb/tb_nn_bit_tx.sv - self-checking bench for nn_bit_tx

module tb_nn_bit_tx;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  in_valid_w;
    logic [2:0]  in_ready_w;
    logic [2:0]  nn_in_w;
    logic [2:0]  nn_1_w;
    logic [2:0]  done_w;
    logic [2:0]  busy_w;
    logic [11:0] in_data_w [3];
    logic [15:0] ws_w [3];

    int total = 0;
    int bad   = 0;
    int exp_ws [3];

    always #5 clk = ~clk;

    // u0: defaults, u1: GAP_CYCLES=2, u2: LSB first
    nn_bit_tx #(.agg_width(12), .GAP_CYCLES(0), .MSB_FIRST(1)) u0 (
        .clk(clk), .rst(rst), .in_valid(in_valid_w[0]), .in_data(in_data_w[0]),
        .in_ready(in_ready_w[0]), .nn_in(nn_in_w[0]), .nn_1(nn_1_w[0]),
        .word_done(done_w[0]), .busy(busy_w[0]), .words_sent(ws_w[0]));

    nn_bit_tx #(.agg_width(12), .GAP_CYCLES(2), .MSB_FIRST(1)) u1 (
        .clk(clk), .rst(rst), .in_valid(in_valid_w[1]), .in_data(in_data_w[1]),
        .in_ready(in_ready_w[1]), .nn_in(nn_in_w[1]), .nn_1(nn_1_w[1]),
        .word_done(done_w[1]), .busy(busy_w[1]), .words_sent(ws_w[1]));

    nn_bit_tx #(.agg_width(12), .GAP_CYCLES(0), .MSB_FIRST(0)) u2 (
        .clk(clk), .rst(rst), .in_valid(in_valid_w[2]), .in_data(in_data_w[2]),
        .in_ready(in_ready_w[2]), .nn_in(nn_in_w[2]), .nn_1(nn_1_w[2]),
        .word_done(done_w[2]), .busy(busy_w[2]), .words_sent(ws_w[2]));

    typedef struct {
        int          k;
        logic [11:0] data;
        logic [11:0] exp_stream;   // transmission order, first bit at [11]
    } vec_t;

    vec_t vecs [7];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic capture(input int k, input int n, output logic [63:0] bits,
                           output logic [63:0] v, output logic [63:0] d);
        bits = '0; v = '0; d = '0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            bits = {bits[62:0], nn_in_w[k]};
            v    = {v[62:0], nn_1_w[k]};
            d    = {d[62:0], done_w[k]};
        end
    endtask

    // Single word into an idle instance; returns just after the accepting edge.
    task automatic offer(input int k, input logic [11:0] data);
        in_valid_w[k] = 1'b1;
        in_data_w[k]  = data;
        @(posedge clk); #1;
        in_valid_w[k] = 1'b0;
        in_data_w[k]  = 12'h000;
    endtask

    // Two words offered back to back; the second lands in the holding register.
    task automatic pair(input int k, input logic [11:0] w0, input logic [11:0] w1,
                        input int n, output logic [63:0] bits,
                        output logic [63:0] v, output logic [63:0] d);
        in_valid_w[k] = 1'b1;
        in_data_w[k]  = w0;
        @(posedge clk); #1;
        in_data_w[k]  = w1;
        fork
            capture(k, n, bits, v, d);
            begin
                @(posedge clk); #1;
                in_valid_w[k] = 1'b0;
                in_data_w[k]  = 12'h000;
            end
        join
    endtask

    logic [63:0] bits, v, d;
    logic [11:0] bp_words [3];
    int          acc_cyc [3];

    initial begin
        vecs[0] = '{0, 12'hA5C, 12'b1010_0101_1100};
        vecs[1] = '{0, 12'hFFF, 12'b1111_1111_1111};
        vecs[2] = '{0, 12'h801, 12'b1000_0000_0001};
        vecs[3] = '{0, 12'h000, 12'b0000_0000_0000};
        vecs[4] = '{2, 12'h003, 12'b1100_0000_0000};
        vecs[5] = '{2, 12'h800, 12'b0000_0000_0001};
        vecs[6] = '{2, 12'hA5C, 12'b0011_1010_0101};
        bp_words[0] = 12'h123;
        bp_words[1] = 12'h456;
        bp_words[2] = 12'h789;

        for (int k = 0; k < 3; k++) begin
            exp_ws[k]    = 0;
            in_data_w[k] = 12'h000;
        end
        in_valid_w = 3'b000;
        rst = 1'b1;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_in_ready", 64'(in_ready_w), 64'(3'b000));
        check("rst_nn_1",     64'(nn_1_w),     64'(3'b000));
        check("rst_nn_in",    64'(nn_in_w),    64'(3'b000));
        check("rst_busy",     64'(busy_w),     64'(3'b000));
        check("rst_done",     64'(done_w),     64'(3'b000));
        check("rst_ws",       64'(ws_w[0]),    64'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_ready", 64'(in_ready_w), 64'(3'b111));
        @(posedge clk); #1;

        // Single-word table
        for (int i = 0; i < 7; i++) begin
            offer(vecs[i].k, vecs[i].data);
            capture(vecs[i].k, 13, bits, v, d);
            exp_ws[vecs[i].k]++;
            check($sformatf("vec%0d_bits", i), bits, 64'({vecs[i].exp_stream, 1'b0}));
            check($sformatf("vec%0d_nn_1", i), v,    64'(13'h1FFE));
            check($sformatf("vec%0d_done", i), d,    64'(13'h0002));
            check($sformatf("vec%0d_ws", i),   64'(ws_w[vecs[i].k]), 64'(exp_ws[vecs[i].k]));
            @(posedge clk); #1;
        end

        // Back-to-back, no gap
        pair(0, 12'hFFF, 12'h001, 25, bits, v, d);
        exp_ws[0] += 2;
        check("b2b_bits", bits, 64'({12'hFFF, 12'h001, 1'b0}));
        check("b2b_nn_1", v,    64'(25'h1FFFFFE));
        check("b2b_done", d,    64'(25'h0002002));
        check("b2b_ws",   64'(ws_w[0]), 64'(exp_ws[0]));
        @(posedge clk); #1;

        // Backpressure: three words offered continuously
        fork
            capture(0, 38, bits, v, d);
            begin
                int cyc = 0;
                for (int w = 0; w < 3; w++) begin
                    logic r;
                    in_valid_w[0] = 1'b1;
                    in_data_w[0]  = bp_words[w];
                    acc_cyc[w]    = -1;
                    for (int t = 0; t < 40; t++) begin
                        @(negedge clk);
                        cyc++;
                        r = in_ready_w[0];
                        @(posedge clk); #1;
                        if (r) begin
                            acc_cyc[w] = cyc;
                            break;
                        end
                    end
                end
                in_valid_w[0] = 1'b0;
                in_data_w[0]  = 12'h000;
            end
        join
        exp_ws[0] += 3;
        check("bp_acc0", 64'(acc_cyc[0]), 64'(1));
        check("bp_acc1", 64'(acc_cyc[1]), 64'(2));
        check("bp_acc2", 64'(acc_cyc[2]), 64'(14));
        check("bp_bits", bits, 64'({1'b0, 36'h123456789, 1'b0}));
        check("bp_nn_1", v,    64'({1'b0, {36{1'b1}}, 1'b0}));
        check("bp_done", d,    64'(38'h0002002002));
        check("bp_ws",   64'(ws_w[0]), 64'(exp_ws[0]));
        @(posedge clk); #1;

        // Gap of two idle cycles between frames
        pair(1, 12'hFFF, 12'hFFF, 27, bits, v, d);
        exp_ws[1] += 2;
        check("gap_bits", bits, 64'({12'hFFF, 2'b00, 12'hFFF, 1'b0}));
        check("gap_nn_1", v,    64'({12'hFFF, 2'b00, 12'hFFF, 1'b0}));
        check("gap_done", d,    64'(27'h0008002));
        check("gap_ws",   64'(ws_w[1]), 64'(exp_ws[1]));
        @(posedge clk); #1;

        // Asynchronous reset mid-word with a second word held
        in_valid_w[0] = 1'b1;
        in_data_w[0]  = 12'hA5C;
        @(posedge clk); #1;
        in_data_w[0]  = 12'h111;
        @(posedge clk); #1;
        in_valid_w[0] = 1'b0;
        repeat (4) @(posedge clk);
        #3;
        check("mid_nn_1_before", 64'(nn_1_w[0]), 64'(1));
        check("mid_busy_before", 64'(busy_w[0]), 64'(1));
        rst = 1'b1;
        #1;
        check("mid_rst_nn_1",  64'(nn_1_w[0]),     64'(0));
        check("mid_rst_nn_in", 64'(nn_in_w[0]),    64'(0));
        check("mid_rst_ready", 64'(in_ready_w[0]), 64'(0));
        check("mid_rst_busy",  64'(busy_w[0]),     64'(0));
        check("mid_rst_ws",    64'(ws_w[0]),       64'(0));
        @(posedge clk); #3;
        rst = 1'b0;
        exp_ws[0] = 0;
        capture(0, 15, bits, v, d);
        check("post_rst_nn_1", v, 64'(0));
        check("post_rst_done", d, 64'(0));
        check("post_rst_ws",   64'(ws_w[0]), 64'(0));
        @(posedge clk); #1;
        offer(0, 12'h5A5);
        capture(0, 13, bits, v, d);
        exp_ws[0]++;
        check("post_rst_word", bits, 64'({12'h5A5, 1'b0}));
        check("post_rst_ws1",  64'(ws_w[0]), 64'(exp_ws[0]));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
